// File: rtl/adpll_pkg.sv
// ADPLL bank sequencer shared types.
// State encoding, mode codes and counter sizing.
package adpll_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PU     = 3'd1,
    S_ACQ    = 3'd2,
    S_SETTLE = 3'd3,
    S_TRACK  = 3'd4,
    S_FAIL   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    MODE_PD   = 2'd0,
    MODE_TEST = 2'd1,
    MODE_RX   = 2'd2,
    MODE_TX   = 2'd3
  } adpll_mode_e;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/adpll_bank_seq_if.sv
// Control/status bundle between loop filter,
// bank sequencer and bank decoders.
interface adpll_bank_seq_if #(
  parameter int NBANK = 3,
  parameter int WW    = 8
);
  localparam int BW = $clog2(NBANK);

  logic                 en;
  logic                 run;
  logic                 soft_rst;
  logic signed [WW-1:0] otw;
  logic                 otw_vld;

  logic                 dco_pd;
  logic                 tdc_pd;
  logic                 tdc_pd_inj;
  logic [BW-1:0]        bank_sel;
  logic                 loop_rst;
  logic [NBANK*WW-1:0]  word_fixed;
  logic [NBANK-1:0]     bank_locked;
  logic                 channel_lock;
  logic                 err_timeout;
  logic                 lock_lost;

  modport master (
    output en, run, soft_rst, otw, otw_vld,
    input  dco_pd, tdc_pd, tdc_pd_inj,
    input  bank_sel, loop_rst, word_fixed,
    input  bank_locked, channel_lock,
    input  err_timeout, lock_lost
  );

  modport slave (
    input  en, run, soft_rst, otw, otw_vld,
    output dco_pd, tdc_pd, tdc_pd_inj,
    output bank_sel, loop_rst, word_fixed,
    output bank_locked, channel_lock,
    output err_timeout, lock_lost
  );
endinterface

// File: rtl/adpll_lock_det.sv
// Two-candidate lock detector: declares lock when one
// tuning word is seen LOCK_CNT times among valid samples.
module adpll_lock_det
  import adpll_pkg::*;
#(
  parameter int WW       = 8,
  parameter int LOCK_CNT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          enable,
  input  logic [WW-1:0] sample,
  input  logic          valid,
  output logic          lock,
  output logic [WW-1:0] lock_word
);

  localparam int CW = cnt_w(LOCK_CNT);
  typedef logic [CW-1:0] cnt_t;

  logic [WW-1:0] r_a;
  logic [WW-1:0] r_b;
  cnt_t          r_cnt_a;
  cnt_t          r_cnt_b;

  logic w_upd;
  logic w_hit_a;
  logic w_hit_b;
  cnt_t w_inc_a;
  cnt_t w_inc_b;

  assign w_upd   = enable & valid;
  assign w_hit_a = (sample == r_a);
  assign w_hit_b = !w_hit_a && (sample == r_b);
  assign w_inc_a = r_cnt_a + 1'b1;
  assign w_inc_b = r_cnt_b + 1'b1;

  assign lock = w_upd &&
    ((w_hit_a && w_inc_a == cnt_t'(LOCK_CNT)) ||
     (w_hit_b && w_inc_b == cnt_t'(LOCK_CNT)));
  assign lock_word = w_hit_a ? r_a : r_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a     <= '1;
      r_b     <= '1;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (clr) begin
      r_a     <= '1;
      r_b     <= '1;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (w_upd) begin
      if (w_hit_a) begin
        r_cnt_a <= w_inc_a;
      end else if (w_hit_b) begin
        r_cnt_b <= w_inc_b;
      end else begin
        // older candidate survives as B
        r_b     <= r_a;
        r_cnt_b <= r_cnt_a;
        r_a     <= sample;
        r_cnt_a <= cnt_t'(1);
      end
    end
  end

endmodule

// File: rtl/adpll_bank_seq.sv
// ADPLL controller: power-up sequencing, per-bank
// coarse-to-fine acquisition, settle and tracking.
module adpll_bank_seq
  import adpll_pkg::*;
#(
  parameter int NBANK    = 3,
  parameter int WW       = 8,
  parameter int LOCK_CNT = 8,
  parameter int PU_STEP  = 16,
  parameter int SETTLE   = 480,
  parameter int TMO      = 1023,
  parameter int LOSS_CNT = 4
) (
  input logic             clk,
  input logic             rst,
  adpll_bank_seq_if.slave bus
);

  localparam int BW     = $clog2(NBANK);
  localparam int PU_END = 3 * PU_STEP;
  localparam int M1 = (PU_END > SETTLE) ? PU_END : SETTLE;
  localparam int M2 = (M1 > TMO) ? M1 : TMO;
  localparam int CM = (M2 > LOSS_CNT) ? M2 : LOSS_CNT;
  localparam int CW = cnt_w(CM);
  typedef logic [CW-1:0] cnt_t;

  localparam logic [WW-1:0] SMAX =
    {1'b0, {(WW-1){1'b1}}};
  localparam logic [WW-1:0] SMIN =
    {1'b1, {(WW-1){1'b0}}};

  state_e              r_state, w_state;
  cnt_t                r_cnt, w_cnt;
  logic                r_dco, w_dco;
  logic                r_tdc, w_tdc;
  logic                r_inj, w_inj;
  logic [BW-1:0]       r_sel, w_sel;
  logic                r_lrst, w_lrst;
  logic [NBANK*WW-1:0] r_word, w_word;
  logic [NBANK-1:0]    r_lkd, w_lkd;
  logic                r_chl, w_chl;
  logic                r_err, w_err;
  logic                r_lost, w_lost;

  logic          w_go;
  logic          w_lock;
  logic [WW-1:0] w_lock_word;
  logic          w_det_en;
  logic          w_det_clr;
  cnt_t          w_inc;
  logic          w_sat;
  logic          w_last;

  assign w_go      = bus.run & ~bus.soft_rst;
  assign w_det_en  = bus.en & w_go & (r_state == S_ACQ);
  assign w_det_clr = bus.en &
                     ((r_state != S_ACQ) | w_lock);
  assign w_inc     = r_cnt + 1'b1;
  assign w_sat     = (bus.otw == SMAX) ||
                     (bus.otw == SMIN);
  assign w_last    = (r_sel == BW'(NBANK - 2));

  adpll_lock_det #(
    .WW       (WW),
    .LOCK_CNT (LOCK_CNT)
  ) u_det (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_det_clr),
    .enable    (w_det_en),
    .sample    (bus.otw),
    .valid     (bus.otw_vld),
    .lock      (w_lock),
    .lock_word (w_lock_word)
  );

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_dco   = r_dco;
    w_tdc   = r_tdc;
    w_inj   = r_inj;
    w_sel   = r_sel;
    w_lrst  = 1'b0;
    w_word  = r_word;
    w_lkd   = r_lkd;
    w_chl   = r_chl;
    w_err   = r_err;
    w_lost  = r_lost;
    if (!w_go) begin
      w_state = S_IDLE;
      w_cnt   = '0;
      w_dco   = 1'b1;
      w_tdc   = 1'b1;
      w_inj   = 1'b1;
      w_sel   = '0;
      w_word  = '0;
      w_lkd   = '0;
      w_chl   = 1'b0;
      if (bus.soft_rst) begin
        w_err  = 1'b0;
        w_lost = 1'b0;
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state = S_PU;
          w_cnt   = '0;
          w_dco   = 1'b0;
          w_tdc   = 1'b1;
          w_inj   = 1'b1;
          w_sel   = '0;
          w_word  = '0;
          w_lkd   = '0;
          w_chl   = 1'b0;
        end
        S_PU: begin
          w_cnt = w_inc;
          if (w_inc == cnt_t'(PU_STEP))
            w_tdc = 1'b0;
          if (w_inc == cnt_t'(2 * PU_STEP))
            w_inj = 1'b0;
          if (w_inc == cnt_t'(PU_END)) begin
            w_state = S_ACQ;
            w_sel   = '0;
            w_lrst  = 1'b1;
            w_cnt   = '0;
          end
        end
        S_ACQ: begin
          // a lock on the timeout cycle still counts
          if (w_lock) begin
            w_word[r_sel*WW +: WW] = w_lock_word;
            w_lkd[r_sel] = 1'b1;
            w_sel  = r_sel + 1'b1;
            w_lrst = 1'b1;
            w_cnt  = '0;
            if (w_last)
              w_state = S_SETTLE;
          end else if (w_inc == cnt_t'(TMO)) begin
            w_state = S_FAIL;
            w_err   = 1'b1;
            w_chl   = 1'b0;
          end else begin
            w_cnt = w_inc;
          end
        end
        S_SETTLE: begin
          w_cnt = w_inc;
          if (w_inc == cnt_t'(SETTLE)) begin
            w_state = S_TRACK;
            w_chl   = 1'b1;
            w_cnt   = '0;
          end
        end
        S_TRACK: begin
          if (bus.otw_vld) begin
            w_cnt = w_sat ? w_inc : '0;
            if (w_sat &&
                w_inc == cnt_t'(LOSS_CNT)) begin
              w_state = S_ACQ;
              w_lost  = 1'b1;
              w_chl   = 1'b0;
              w_lkd   = '0;
              w_sel   = '0;
              w_lrst  = 1'b1;
              w_cnt   = '0;
            end
          end
        end
        S_FAIL: begin
          w_chl = 1'b0;
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dco   <= 1'b1;
      r_tdc   <= 1'b1;
      r_inj   <= 1'b1;
      r_sel   <= '0;
      r_lrst  <= 1'b0;
      r_word  <= '0;
      r_lkd   <= '0;
      r_chl   <= 1'b0;
      r_err   <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      // pulse must not stretch while disabled
      r_lrst <= bus.en & w_lrst;
      if (bus.en) begin
        r_state <= w_state;
        r_cnt   <= w_cnt;
        r_dco   <= w_dco;
        r_tdc   <= w_tdc;
        r_inj   <= w_inj;
        r_sel   <= w_sel;
        r_word  <= w_word;
        r_lkd   <= w_lkd;
        r_chl   <= w_chl;
        r_err   <= w_err;
        r_lost  <= w_lost;
      end
    end
  end

  assign bus.dco_pd       = r_dco;
  assign bus.tdc_pd       = r_tdc;
  assign bus.tdc_pd_inj   = r_inj;
  assign bus.bank_sel     = r_sel;
  assign bus.loop_rst     = r_lrst;
  assign bus.word_fixed   = r_word;
  assign bus.bank_locked  = r_lkd;
  assign bus.channel_lock = r_chl;
  assign bus.err_timeout  = r_err;
  assign bus.lock_lost    = r_lost;

endmodule

// File: tb/tb_adpll_bank_seq.sv
// Bench for adpll_bank_seq: loop_rst events are
// scored against a queue of expected bank states.
module tb_adpll_bank_seq;

  localparam int NB = 3;
  localparam int WW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  adpll_bank_seq_if #(.NBANK(NB), .WW(WW)) bus ();

  adpll_bank_seq #(
    .NBANK    (NB),
    .WW       (WW),
    .LOCK_CNT (8),
    .PU_STEP  (16),
    .SETTLE   (480),
    .TMO      (1023),
    .LOSS_CNT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  lkd;
    logic [23:0] word;
  } ev_t;

  ev_t  sb[$];
  logic prev_lr = 1'b0;

  task automatic push_ev(input logic [1:0] s,
                         input logic [2:0] l,
                         input logic [23:0] w);
    ev_t e;
    e.sel  = s;
    e.lkd  = l;
    e.word = w;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst && bus.loop_rst) begin
      check("lr_width", prev_lr, 0);
      if (sb.size() == 0) begin
        check("sb_unexpected", bus.loop_rst, 0);
      end else begin
        e = sb.pop_front();
        check("ev_sel", bus.bank_sel, e.sel);
        check("ev_locked", bus.bank_locked, e.lkd);
        check("ev_word", bus.word_fixed, e.word);
      end
    end
    prev_lr <= bus.loop_rst;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sample(input logic [7:0] v);
    bus.otw     = v;
    bus.otw_vld = 1'b1;
    tick(1);
  endtask

  task automatic check_rst_vals(input string p);
    check({p, "_dco"}, bus.dco_pd, 1);
    check({p, "_tdc"}, bus.tdc_pd, 1);
    check({p, "_inj"}, bus.tdc_pd_inj, 1);
    check({p, "_sel"}, bus.bank_sel, 0);
    check({p, "_lrst"}, bus.loop_rst, 0);
    check({p, "_word"}, bus.word_fixed, 0);
    check({p, "_lkd"}, bus.bank_locked, 0);
    check({p, "_chl"}, bus.channel_lock, 0);
    check({p, "_err"}, bus.err_timeout, 0);
    check({p, "_lost"}, bus.lock_lost, 0);
  endtask

  initial begin
    bus.en       = 1'b1;
    bus.run      = 1'b0;
    bus.soft_rst = 1'b0;
    bus.otw      = '0;
    bus.otw_vld  = 1'b0;
    tick(2);
    check_rst_vals("rst");
    rst = 1'b1;
    tick(2);
    check("idle_dco", bus.dco_pd, 1);

    // power-up: entry edge is cycle 0
    bus.run = 1'b1;
    tick(1);
    check("pu_dco", bus.dco_pd, 0);
    check("pu_tdc0", bus.tdc_pd, 1);
    tick(15);
    check("pu_tdc15", bus.tdc_pd, 1);
    tick(1);
    check("pu_tdc16", bus.tdc_pd, 0);
    check("pu_inj16", bus.tdc_pd_inj, 1);
    tick(15);
    check("pu_inj31", bus.tdc_pd_inj, 1);
    tick(1);
    check("pu_inj32", bus.tdc_pd_inj, 0);
    push_ev(2'd0, 3'b000, 24'h0);
    tick(15);
    check("pu_lr47", bus.loop_rst, 0);
    tick(1);

    // bank 0: constant word
    push_ev(2'd1, 3'b001, 24'h000005);
    repeat (8) sample(8'd5);
    bus.otw_vld = 1'b0;
    check("b0_lkd", bus.bank_locked, 3'b001);

    // bank 1: alternating 3/4, 3 reaches 8 first
    push_ev(2'd2, 3'b011, 24'h000305);
    for (int i = 0; i < 15; i++)
      sample((i % 2) != 0 ? 8'd4 : 8'd3);
    bus.otw_vld = 1'b0;
    check("set_chl0", bus.channel_lock, 0);

    // settle ignores valid samples
    repeat (479) begin
      bus.otw     = 8'h7f;
      bus.otw_vld = 1'($urandom_range(0, 1));
      tick(1);
    end
    bus.otw_vld = 1'b0;
    bus.otw     = 8'h00;
    check("set_chl479", bus.channel_lock, 0);
    tick(1);
    check("trk_chl", bus.channel_lock, 1);
    check("trk_sel", bus.bank_sel, 2);

    // three saturated then a normal sample
    repeat (3) sample(8'h7f);
    sample(8'h00);
    bus.otw_vld = 1'b0;
    tick(2);
    check("trk_nolost", bus.lock_lost, 0);
    check("trk_chl_hold", bus.channel_lock, 1);

    // mixed min/max saturation -> loss
    push_ev(2'd0, 3'b000, 24'h000305);
    sample(8'h80);
    sample(8'h80);
    sample(8'h7f);
    sample(8'h7f);
    bus.otw_vld = 1'b0;
    check("loss_flag", bus.lock_lost, 1);
    check("loss_chl", bus.channel_lock, 0);
    check("loss_lkd", bus.bank_locked, 0);

    // never-repeating words -> timeout
    for (int i = 0; i < 1022; i++)
      sample(8'(i));
    check("tmo_1022", bus.err_timeout, 0);
    sample(8'(1022));
    check("tmo_1023", bus.err_timeout, 1);
    check("fail_chl", bus.channel_lock, 0);
    check("fail_inj", bus.tdc_pd_inj, 0);
    check("fail_dco", bus.dco_pd, 0);
    check("fail_lost", bus.lock_lost, 1);
    bus.otw_vld = 1'b0;
    tick(5);
    check("fail_hold", bus.err_timeout, 1);

    bus.soft_rst = 1'b1;
    tick(1);
    bus.soft_rst = 1'b0;
    check("srst_err", bus.err_timeout, 0);
    check("srst_lost", bus.lock_lost, 0);
    check("srst_dco", bus.dco_pd, 1);

    // enable freeze inside power-up
    tick(1);
    check("pu2_dco", bus.dco_pd, 0);
    tick(10);
    bus.en = 1'b0;
    tick(100);
    check("en0_tdc", bus.tdc_pd, 1);
    check("en0_dco", bus.dco_pd, 0);
    bus.en = 1'b1;
    tick(5);
    check("en1_tdc15", bus.tdc_pd, 1);
    tick(1);
    check("en1_tdc16", bus.tdc_pd, 0);
    push_ev(2'd0, 3'b000, 24'h0);
    tick(32);

    push_ev(2'd1, 3'b001, 24'h000009);
    repeat (8) sample(8'd9);
    sample(8'd1);
    sample(8'd2);
    bus.otw_vld = 1'b0;

    // async reset mid-acquisition
    #2 rst = 1'b0;
    #1 check_rst_vals("arst");
    tick(2);
    check("sb_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/adpll_bank_seq.md
Name: adpll_bank_seq

Overview:
- Parametrised successor of the ADPLL control state machine.
- Sequences DCO/TDC power-up, then drives coarse-to-fine acquisition across NBANK capacitor banks. A two-candidate lock detector freezes each bank's word before moving to the next bank.
- Adds a per-bank acquisition timeout and a lock-loss monitor in tracking, neither of which the current controller has.
- Sits between the loop filter (rounded, saturated OTW) and the row/column bank decoders.

Parameters:
NBANK, 3, number of capacitor banks; minimum 2
WW, 8, signed tuning-word width
LOCK_CNT, 8, equal valid samples needed to declare bank lock
PU_STEP, 16, cycles between power-up steps
SETTLE, 480, cycles in last bank before channel_lock
TMO, 1023, maximum acquisition cycles per bank before failure
LOSS_CNT, 4, consecutive saturated samples in TRACK that declare lock loss

Ports:
clk  in  1  loop clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-low
en  in  1  clock enable; when low, all state holds
run  in  1  level; high = acquire/track, low = return to IDLE
soft_rst  in  1  one-cycle pulse on FCW or mode change; forces IDLE
otw  in  WW  signed rounded/saturated tuning word from loop filter
otw_vld  in  1  otw sample valid
dco_pd  out  1  DCO power-down
tdc_pd  out  1  TDC power-down
tdc_pd_inj  out  1  TDC injection power-down
bank_sel  out  $clog2(NBANK)  bank currently driven by the loop
loop_rst  out  1  one-cycle accumulator/filter reset pulse
word_fixed  out  NBANK*WW  frozen words; bank k occupies bits [k*WW +: WW]
bank_locked  out  NBANK  per-bank frozen flag
channel_lock  out  1  channel acquired
err_timeout  out  1  sticky; acquisition failed
lock_lost  out  1  sticky; saturation detected while tracking

Behaviour:
- Reset (rst=0) values:
  - state=IDLE; dco_pd=tdc_pd=tdc_pd_inj=1.
  - bank_sel=0, loop_rst=0, word_fixed=0, bank_locked=0.
  - channel_lock=0, err_timeout=0, lock_lost=0; all counters 0.
- Global transitions (evaluated after en gating):
  - soft_rst=1 or run=0 in any state -> IDLE next cycle.
  - soft_rst also clears err_timeout and lock_lost.
- IDLE:
  - All pd outputs = 1; word_fixed, bank_locked, channel_lock cleared.
  - run=1 and soft_rst=0 -> PU with cnt=0.
- PU: cnt increments every enabled cycle.
  - dco_pd=0 from PU entry.
  - tdc_pd=0 when cnt==PU_STEP.
  - tdc_pd_inj=0 when cnt==2*PU_STEP.
  - cnt==3*PU_STEP -> ACQ, bank_sel=0, loop_rst=1 for exactly one cycle, counters cleared.
- ACQ (bank_sel=k, k<NBANK-1):
  - Lock detector keeps candidates A and B, each with a count. Both reset to all-ones value and count 0.
  - On otw_vld only: otw==A -> cntA++; else otw==B -> cntB++; else B<=A, cntB<=cntA, A<=otw, cntA<=1.
  - When the incremented count reaches LOCK_CNT: word_fixed[k]<=that candidate; bank_locked[k]<=1; bank_sel<=k+1; loop_rst pulse; detector and timeout counter cleared.
  - If k+1==NBANK-1, go to SETTLE.
  - Timeout counter increments every enabled cycle. At TMO with no lock -> FAIL.
  - Lock and timeout on the same cycle: lock wins.
- SETTLE (bank NBANK-1 live, detector disabled):
  - Counts SETTLE cycles, then channel_lock=1 and -> TRACK.
  - The loop_rst that enters SETTLE happens on the same cycle as its count reset.
- TRACK:
  - channel_lock=1.
  - Saturation counter increments on otw_vld with otw == max or min signed WW value; clears on any other valid sample.
  - Counter reaching LOSS_CNT: lock_lost<=1, channel_lock<=0, all bank_locked cleared, bank_sel=0, loop_rst pulse, -> ACQ.
- FAIL:
  - err_timeout=1, pd outputs keep their PU values, channel_lock=0.
  - Leaves only via soft_rst or run=0.
- loop_rst is never high for two consecutive cycles.
- Async reset mid-operation returns all outputs to reset values immediately.

Decomposition:
- Shared package adpll_pkg holds:
  - state encoding: IDLE=0, PU=1, ACQ=2, SETTLE=3, TRACK=4, FAIL=5;
  - adpll_mode constants: PD=0, TEST=1, RX=2, TX=3;
  - counter-width helper function.
- Natural sub-module: adpll_lock_det (two-candidate detector).
  - Parametrised by WW and LOCK_CNT.
  - Ports: clr, enable, sample, valid -> lock, lock_word.

Test Plan:
- Power-up: run=1 with defaults -> tdc_pd falls at PU cycle 16, tdc_pd_inj at 32; loop_rst one-cycle pulse at 48; bank_sel=0.
- Coarse/medium lock: bank 0 fed otw=5 for 8 valid samples -> word_fixed[7:0]=5, bank_locked=3'b001, bank_sel=1. Bank 1 fed alternating 3/4 -> lock on the first candidate to reach 8, bank_sel=2.
- Settle: 480 cycles after entering bank 2 -> channel_lock=1, state TRACK. Toggling otw_vld has no effect on timing.
- Timeout: bank 0 fed incrementing otw every cycle -> at cycle 1023 err_timeout=1, channel_lock=0. soft_rst pulse -> IDLE with err_timeout=0.
- Lock loss: in TRACK, 4 valid samples of otw=127 -> lock_lost=1, channel_lock=0, bank_locked=0, bank_sel=0, loop_rst pulse. 3 samples then otw=0 -> no loss.
- Reset/enable: rst low mid-ACQ -> all outputs at reset values immediately. en=0 for 100 cycles in PU -> counters and outputs frozen.
